// File: rtl/pixel_sink_pkg.sv
// Shared constants and types for the pixel sink and its FIFO.
package pixel_sink_pkg;

    localparam int WIDTH       = 160;
    localparam int HEIGHT      = 120;
    localparam int ADDR_W      = 15;
    localparam int SCREEN_SIZE = 19200;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        colour;
    } pixel_t;

endpackage

// File: rtl/pixel_sink_if.sv
// Pixel-plot handshake plus framebuffer write port, bundled for the sink.
interface pixel_sink_if
    import pixel_sink_pkg::*;
;
    logic              plot;
    logic              plot_ready;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [7:0]        colour;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output plot, vga_x, vga_y, colour, mem_busy,
        input  plot_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  plot, vga_x, vga_y, colour, mem_busy,
        output plot_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel entries with a single-cycle flush.
module pixel_fifo
    import pixel_sink_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  pixel_t din,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output pixel_t head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    pixel_t           store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // Entry storage; no reset needed, only valid entries are ever read.
    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr] <= din;
    end

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pixel_sink.sv
// Framebuffer owner: clears the screen, then drains plotted pixels to RAM.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter int         DEPTH        = 4,
    parameter logic [7:0] CLEAR_COLOUR = 8'h00
) (
    input  logic               clock,
    input  logic               reset,
    pixel_sink_if.slave        bus,
    input  logic               clear,
    output logic               clear_done,
    output logic               busy,
    output logic [7:0]         dropped
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH*HEIGHT-1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] y_ext;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    pixel_t            head;
    pixel_t            entry;
    logic              ready;
    logic              write;
    logic              on_screen;
    logic              handshake;
    logic              last_write;

    // x + 160*y via shifts, kept to the framebuffer address width.
    assign y_ext        = ADDR_W'(bus.vga_y);
    assign entry.addr   = (y_ext << 7) + (y_ext << 5) + ADDR_W'(bus.vga_x);
    assign entry.colour = bus.colour;
    assign on_screen    = (int'(bus.vga_x) < WIDTH) && (int'(bus.vga_y) < HEIGHT);
    assign handshake    = bus.plot && ready;
    assign fifo_push    = handshake && on_screen;
    assign last_write   = (state == CLEAR) && write && (clr_cnt == LAST_ADDR);

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (entry),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= CLEAR;
        else       state <= state_nx;
    end

    // Next state and write-port control; reset masks every strobe.
    always_comb begin
        state_nx   = state;
        ready      = 1'b0;
        write      = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state)
            CLEAR: begin
                write = !bus.mem_busy;
                if (write && !clear && clr_cnt == LAST_ADDR) state_nx = RUN;
            end
            RUN: begin
                ready    = !fifo_full && !clear;
                // Pending pixels are discarded by a clear, head included.
                write    = !fifo_empty && !bus.mem_busy && !clear;
                fifo_pop = write;
                if (clear) begin
                    fifo_flush = 1'b1;
                    state_nx   = CLEAR;
                end
            end
            default: state_nx = CLEAR;
        endcase
        if (reset) begin
            ready      = 1'b0;
            write      = 1'b0;
            fifo_pop   = 1'b0;
            fifo_flush = 1'b0;
        end
    end

    // Address/data mux: clear counter during CLEAR, FIFO head otherwise.
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_data = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                bus.mem_addr = clr_cnt;
                bus.mem_data = CLEAR_COLOUR;
            end else begin
                bus.mem_addr = head.addr;
                bus.mem_data = head.colour;
            end
        end
    end

    assign bus.plot_ready = ready;
    assign bus.mem_we     = write;
    assign busy           = reset || (state == CLEAR) || !fifo_empty;

    // Clear counter; any clear request restarts the fill from address 0.
    always_ff @(posedge clock) begin
        if (reset || clear || last_write) clr_cnt <= '0;
        else if (state == CLEAR && write) clr_cnt <= clr_cnt + ADDR_ONE;
    end

    // One pulse after the final fill write, unless that write was restarted.
    always_ff @(posedge clock) begin
        if (reset) clear_done <= 1'b0;
        else       clear_done <= last_write && !clear;
    end

    // Saturating count of off-screen handshakes.
    always_ff @(posedge clock) begin
        if (reset)                                       dropped <= '0;
        else if (handshake && !on_screen && dropped != 8'hFF) dropped <= dropped + 8'd1;
    end
endmodule
